b1_fifo_wr_arb: RTL and testbench



---
 rtl/b1_fifo_pkg.sv | 27 ++
 rtl/b1_fifo_wr_arb_rr.sv | 35 +++
 rtl/b1_fifo_wr_arb.sv | 104 ++++++++++
 tb/tb_b1_fifo_wr_arb.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/b1_fifo_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package b1_fifo_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int unsigned MAX_PORTS = 16;

  // Usable words in a FIFO with awidth address bits (one slot is never filled).
  function automatic int unsigned fifo_cap(input int unsigned awidth);
    return (32'd1 << awidth) - 32'd1;
  endfunction

  // One-hot pick of the first valid port after ptr, wrapping modulo nports.
  function automatic logic [MAX_PORTS-1:0] rr_pick(input logic [MAX_PORTS-1:0] valid,
                                                   input logic [3:0] ptr,
                                                   input int unsigned nports);
    logic [MAX_PORTS-1:0] g;
    int unsigned idx;
    g = '0;
    for (int unsigned i = 1; i <= MAX_PORTS; i++) begin
      idx = (32'(ptr) + i) % nports;
      if (i <= nports && g == '0 && valid[idx[3:0]]) g[idx[3:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/b1_fifo_wr_arb_rr.sv
// Round-robin pick with the registered pointer of the last port served.
module b1_rr_arb
  import b1_fifo_pkg::*;
#(
  parameter int NPORTS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NPORTS-1:0] valid,
  input  logic              upd_en,
  input  logic [NPORTS-1:0] upd_grant,
  output logic [NPORTS-1:0] pick
);

  localparam int PW = $clog2(NPORTS);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] owner_idx;

  always_comb begin
    owner_idx = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (upd_grant[i]) owner_idx = PW'(i);
    end
  end

  assign pick = NPORTS'(rr_pick(MAX_PORTS'(valid), 4'(rr_ptr), NPORTS));

  // Reset to the last port so port 0 wins the first arbitration.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rr_ptr <= PW'(NPORTS - 1);
    else if (upd_en) rr_ptr <= owner_idx;
  end

endmodule

// File: rtl/b1_fifo_wr_arb.sv
// Round-robin arbiter sharing one FIFO write port among NPORTS producers.
//   state | meaning
//   IDLE  | no owner; pick next valid port round-robin
//   BURST | owner streams beats until last or MAX_BURST beats
module b1_fifo_wr_arb
  import b1_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 8,
  parameter int NPORTS    = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NPORTS-1:0]        req_valid_i,
  input  logic [NPORTS-1:0]        req_last_i,
  input  logic [NPORTS*DWIDTH-1:0] req_data_i,
  output logic [NPORTS-1:0]        req_ready_o,
  output logic                     fifo_wrreq_o,
  output logic [DWIDTH-1:0]        fifo_data_o,
  input  logic [AWIDTH-1:0]        fifo_usedw_i,
  output logic [NPORTS-1:0]        grant_o,
  output logic                     busy_o
);

  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [AWIDTH:0] CAP = (AWIDTH+1)'(fifo_cap(AWIDTH));

  arb_state_t          state, state_nxt;
  logic [NPORTS-1:0]   grant_nxt;
  logic [NPORTS-1:0]   pick;
  logic [BCW-1:0]      beat_cnt, beat_cnt_nxt;
  logic [DWIDTH-1:0]   beat_data;
  logic                space_ok, fire, last_g, burst_end, rr_upd;

  b1_rr_arb #(.NPORTS(NPORTS)) u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid     (req_valid_i),
    .upd_en    (rr_upd),
    .upd_grant (grant_o),
    .pick      (pick)
  );

  // The write registered last cycle is not yet reflected in usedw.
  assign space_ok    = ({1'b0, fifo_usedw_i} + {{AWIDTH{1'b0}}, fifo_wrreq_o}) < CAP;
  assign req_ready_o = (state == BURST && space_ok) ? grant_o : '0;
  assign fire        = |(req_valid_i & req_ready_o);
  assign last_g      = |(req_last_i & grant_o);
  assign burst_end   = fire && (last_g || beat_cnt == BCW'(MAX_BURST - 1));
  assign busy_o      = (state == BURST);

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (grant_o[i]) beat_data = req_data_i[i*DWIDTH +: DWIDTH];
    end
  end

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_o;
    beat_cnt_nxt = beat_cnt;
    rr_upd       = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid_i) begin
          state_nxt    = BURST;
          grant_nxt    = pick;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (fire) beat_cnt_nxt = beat_cnt + 1'b1;
        if (burst_end) begin
          state_nxt = IDLE;
          grant_nxt = '0;
          rr_upd    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_o      <= '0;
      beat_cnt     <= '0;
      fifo_wrreq_o <= 1'b0;
      fifo_data_o  <= '0;
    end else begin
      grant_o      <= grant_nxt;
      beat_cnt     <= beat_cnt_nxt;
      fifo_wrreq_o <= fire;
      if (fire) fifo_data_o <= beat_data;
    end
  end

endmodule

// File: tb/tb_b1_fifo_wr_arb.sv
// Directed bench for b1_fifo_wr_arb with a FIFO-level model and write scoreboard.
module tb_b1_fifo_wr_arb;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int NP = 4;
  localparam int MB = 4;

  logic            clk_i;
  logic            rst_i;
  logic [NP-1:0]   req_valid;
  logic [NP-1:0]   req_last;
  logic [NP*DW-1:0] req_data;
  logic [NP-1:0]   req_ready;
  logic            fifo_wrreq;
  logic [DW-1:0]   fifo_data;
  logic [AW-1:0]   fifo_usedw;
  logic [NP-1:0]   grant;
  logic            busy;

  b1_fifo_wr_arb #(.DWIDTH(DW), .AWIDTH(AW), .NPORTS(NP), .MAX_BURST(MB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid),
    .req_last_i   (req_last),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .fifo_wrreq_o (fifo_wrreq),
    .fifo_data_o  (fifo_data),
    .fifo_usedw_i (fifo_usedw),
    .grant_o      (grant),
    .busy_o       (busy)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [8:0] beats[NP][$];
  logic [7:0] sb[$];
  int errors = 0;
  int checks = 0;
  int fifo_lvl = 0;
  logic rd_en = 1'b1;
  int cyc = 0;
  int nwr = 0;
  int first_w = -1;
  int last_w = -1;
  logic [NP-1:0] grant_s, ready_s;
  logic busy_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (beats[p].size() != 0) begin
        req_valid[p]          = 1'b1;
        req_last[p]           = beats[p][0][8];
        req_data[p*DW +: DW]  = beats[p][0][7:0];
      end else begin
        req_valid[p]          = 1'b0;
        req_last[p]           = 1'($urandom_range(1));
        req_data[p*DW +: DW]  = 8'($urandom_range(255));
      end
    end
  endtask

  task automatic tick();
    logic [NP-1:0] fire;
    logic wr_s, rd;
    logic [7:0] exp;
    @(negedge clk_i);
    grant_s = grant;
    busy_s  = busy;
    ready_s = req_ready;
    wr_s    = fifo_wrreq;
    rd      = rd_en && fifo_lvl > 0;
    chk("ready_only_owner", 32'(req_ready & ~grant), 32'd0);
    if (wr_s) begin
      chk("no_overflow", 32'(fifo_lvl < 7), 32'd1);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("wr_data", 32'(fifo_data), 32'(exp));
      end
      nwr++;
      if (first_w < 0) first_w = cyc;
      last_w = cyc;
    end
    fire = req_valid & ready_s;
    @(posedge clk_i);
    #1;
    fifo_lvl   = fifo_lvl + int'(wr_s) - int'(rd);
    fifo_usedw = AW'(fifo_lvl);
    for (int p = 0; p < NP; p++) begin
      if (fire[p] && beats[p].size() != 0) void'(beats[p].pop_front());
    end
    cyc++;
    drive();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(sb.size()), 32'd0);
    tick();
    chk({tag, "_idle"}, 32'(busy_s), 32'd0);
  endtask

  task automatic clear_counts();
    nwr = 0;
    first_w = -1;
    last_w = -1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    for (int p = 0; p < NP; p++) beats[p].delete();
    sb.delete();
    drive();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    fifo_usedw = '0;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
    drive();
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // port 0 single 3-beat packet
    clear_counts();
    beats[0].push_back({1'b0, 8'h11});
    beats[0].push_back({1'b0, 8'h22});
    beats[0].push_back({1'b1, 8'h33});
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33);
    drive();
    tick();
    chk("t1_pre_grant", 32'(grant_s), 32'd0);
    tick();
    chk("t1_grant", 32'(grant_s), 32'b0001);
    chk("t1_busy", 32'(busy_s), 32'd1);
    run_drain("t1", 50);
    chk("t1_nwr", 32'(nwr), 32'd3);
    chk("t1_span", 32'(last_w - first_w + 1), 32'd3);

    // all ports, 2-beat packets, port 0 twice
    do_reset();
    clear_counts();
    beats[0].push_back({1'b0, 8'h01}); beats[0].push_back({1'b1, 8'h02});
    beats[0].push_back({1'b0, 8'h03}); beats[0].push_back({1'b1, 8'h04});
    for (int p = 1; p < NP; p++) begin
      beats[p].push_back({1'b0, 8'(p * 16)});
      beats[p].push_back({1'b1, 8'(p * 16 + 1)});
    end
    sb.push_back(8'h01); sb.push_back(8'h02);
    sb.push_back(8'h10); sb.push_back(8'h11);
    sb.push_back(8'h20); sb.push_back(8'h21);
    sb.push_back(8'h30); sb.push_back(8'h31);
    sb.push_back(8'h03); sb.push_back(8'h04);
    drive();
    run_drain("t2", 100);
    chk("t2_nwr", 32'(nwr), 32'd10);
    chk("t2_gaps", 32'(last_w - first_w + 1 - nwr), 32'd4);

    // burst limit: port 2 long packet, port 3 waiting
    clear_counts();
    for (int i = 0; i < 10; i++) beats[2].push_back({1'(i == 9), 8'(8'h20 + i)});
    beats[3].push_back({1'b0, 8'h30}); beats[3].push_back({1'b1, 8'h31});
    for (int i = 0; i < 4; i++) sb.push_back(8'(8'h20 + i));
    sb.push_back(8'h30); sb.push_back(8'h31);
    for (int i = 4; i < 10; i++) sb.push_back(8'(8'h20 + i));
    drive();
    run_drain("t3", 100);
    chk("t3_nwr", 32'(nwr), 32'd12);
    chk("t3_gaps", 32'(last_w - first_w + 1 - nwr), 32'd3);

    // full boundary: no reads, port 1 streams 12 beats
    tick();
    clear_counts();
    rd_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      beats[1].push_back({1'(i == 11), 8'(8'h90 + i)});
      sb.push_back(8'(8'h90 + i));
    end
    drive();
    repeat (40) tick();
    chk("t4_nwr_full", 32'(nwr), 32'd7);
    chk("t4_usedw", 32'(fifo_usedw), 32'd7);
    chk("t4_ready", 32'(ready_s), 32'd0);
    rd_en = 1'b1;
    run_drain("t4", 200);
    chk("t4_nwr_total", 32'(nwr), 32'd12);

    // idle gap inside port 1 packet while port 0 waits
    clear_counts();
    beats[1].push_back({1'b0, 8'h40}); beats[1].push_back({1'b0, 8'h41});
    sb.push_back(8'h40); sb.push_back(8'h41); sb.push_back(8'h42); sb.push_back(8'h43);
    sb.push_back(8'h50); sb.push_back(8'h51);
    drive();
    tick();
    tick();
    chk("t5_grant", 32'(grant_s), 32'b0010);
    beats[0].push_back({1'b0, 8'h50}); beats[0].push_back({1'b1, 8'h51});
    drive();
    for (int n = 0; n < 20 && beats[1].size() != 0; n++) tick();
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t5_hold", 32'(grant_s), 32'b0010);
    end
    beats[1].push_back({1'b0, 8'h42}); beats[1].push_back({1'b1, 8'h43});
    drive();
    run_drain("t5", 50);
    chk("t5_nwr", 32'(nwr), 32'd6);

    // asynchronous reset mid-burst
    clear_counts();
    beats[2].push_back({1'b0, 8'h60}); beats[2].push_back({1'b0, 8'h61});
    beats[2].push_back({1'b0, 8'h62});
    sb.push_back(8'h60); sb.push_back(8'h61); sb.push_back(8'h62);
    drive();
    repeat (3) tick();
    chk("t6_pre_wrreq", 32'(fifo_wrreq), 32'd1);
    chk("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("t6_rst_data", 32'(fifo_data), 32'd0);
    chk("t6_rst_grant", 32'(grant), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    for (int p = 0; p < NP; p++) beats[p].delete();
    sb.delete();
    drive();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_counts();
    beats[3].push_back({1'b0, 8'h70}); beats[3].push_back({1'b1, 8'h71});
    beats[0].push_back({1'b0, 8'h80}); beats[0].push_back({1'b1, 8'h81});
    sb.push_back(8'h80); sb.push_back(8'h81); sb.push_back(8'h70); sb.push_back(8'h71);
    drive();
    tick();
    tick();
    chk("t6_prio", 32'(grant_s), 32'b0001);
    run_drain("t6", 50);
    chk("t6_nwr", 32'(nwr), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
